// File: rtl/lsu_pkg.sv
// Shared types and RV32 load/store size codes for the LSU SRAM controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte/halfword lane handling: store merge into a buffered word
// and load extract with sign/zero extension. Halfword lanes use addr_lo[1] only.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_word  = word;
    ld_data  = word;
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3[1:0])
      2'b00: begin
        st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        ld_data = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        st_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        ld_data = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        st_word = wdata;
        ld_data = word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Load/store unit front-end to a single-port SRAM with combinational read data.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning down.
module lsu_sram_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wren,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic              err_q;

  logic              accept;
  logic              req_bad;
  logic [31:0]       st_word;
  logic [31:0]       ld_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^i_req_addr[31:ADDR_W+2];
  assign accept = i_req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_bad = !f3_legal(i_req_funct3) ||
                   ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                   ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
  assign req_bad = !f3_legal(i_req_funct3);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= i_req_we;
        f3_q    <= i_req_funct3;
        addr_q  <= i_req_addr[ADDR_W+1:0];
        wdata_q <= i_req_wdata;
        err_q   <= req_bad;
      end
      if (state_q == READ) buf_q <= i_mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          if (req_bad)                                       state_d = RESP;
          else if (i_req_we && (i_req_funct3[1:0] == 2'b10)) state_d = WRITE;
          else                                               state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_lane_align u_lane_align (
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .word    (buf_q),
    .wdata   (wdata_q),
    .st_word (st_word),
    .ld_data (ld_data)
  );

  // Strobes are gated by reset so an edge that aborts WRITE/RESP never sees them.
  always_comb begin
    o_req_ready = (state_q == IDLE);
    o_rsp_valid = (state_q == RESP) && i_rst_n;
    o_rsp_err   = (state_q == RESP) && err_q;
    o_rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ld_data : '0;
    o_mem_addr  = (state_q == IDLE) ? '0 : addr_q[ADDR_W+1:2];
    o_mem_wren  = (state_q == WRITE) && i_rst_n;
    o_mem_wdata = (state_q == WRITE) ? st_word : '0;
  end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Scoreboard bench for lsu_sram_ctrl: SRAM model, reference memory and response/write queues.
module tb_lsu_sram_ctrl;

  localparam int unsigned ADDR_W = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [ADDR_W-1:0] o_mem_addr;
  logic        o_mem_wren;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  always #5 i_clk = ~i_clk;

  lsu_sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wren   (o_mem_wren),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata)
  );

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];
  assign i_mem_rdata = mem[o_mem_addr];
  always @(posedge i_clk) if (o_mem_wren) mem[o_mem_addr] <= o_mem_wdata;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int unsigned cyc; } rsp_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; int unsigned cyc; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge i_clk) begin
    rsp_t r;
    wr_t  w;
    if (o_rsp_valid) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp_valid", 32'd1, 32'd0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_rdata", o_rsp_rdata, r.rdata);
        chk("rsp_err",   {31'd0, o_rsp_err}, {31'd0, r.err});
        chk("rsp_cycle", cyc, r.cyc);
      end
    end
    if (o_mem_wren) begin
      if (wr_q.size() == 0) chk("unexpected_mem_wren", 32'd1, 32'd0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr",  {16'd0, o_mem_addr}, {16'd0, w.addr});
        chk("wr_data",  o_mem_wdata, w.data);
        chk("wr_cycle", cyc, w.cyc);
      end
    end
  end

  // Reference: expected results from word memory contents using shifts and masks.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int unsigned n = 0;
    int unsigned acc;
    logic        legal, mis, trap;
    logic [15:0] idx;
    logic [31:0] w, nw, ld, b, h;
    int unsigned sh;
    while (!o_req_ready && n < 20) begin @(negedge i_clk); n++; end
    if (!o_req_ready) begin chk("req_ready_timeout", 32'd0, 32'd1); return; end
`ifdef LSU_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    acc   = cyc;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    mis   = trap && (((f3[1:0] == 2'd1) && addr[0]) || ((f3[1:0] == 2'd2) && (addr[1:0] != 2'd0)));
    idx   = addr[17:2];
    w     = ref_mem[idx];
    if (!legal || mis) begin
      rsp_q.push_back('{32'd0, 1'b1, acc + 1});
    end else if (we) begin
      if (f3[1:0] == 2'd0) begin
        sh = 8 * addr[1:0];
        nw = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
      end else if (f3[1:0] == 2'd1) begin
        sh = 16 * addr[1];
        nw = (w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
      end else nw = wdata;
      if (f3[1:0] == 2'd2) begin
        wr_q.push_back('{idx, nw, acc + 1});
        rsp_q.push_back('{32'd0, 1'b0, acc + 2});
      end else begin
        wr_q.push_back('{idx, nw, acc + 2});
        rsp_q.push_back('{32'd0, 1'b0, acc + 3});
      end
      ref_mem[idx] = nw;
    end else begin
      if (f3[1:0] == 2'd0) begin
        b  = (w >> (8 * addr[1:0])) & 32'hFF;
        ld = (f3 == 3'd0 && b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      end else if (f3[1:0] == 2'd1) begin
        h  = (w >> (16 * addr[1])) & 32'hFFFF;
        ld = (f3 == 3'd1 && h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      end else ld = w;
      rsp_q.push_back('{ld, 1'b0, acc + 2});
    end
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0 || !o_req_ready) && n < 20) begin
      @(negedge i_clk); n++;
    end
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("wr_queue_drained",  wr_q.size(),  32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  codes [0:9];
    codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd1, 3'd3, 3'd7};
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0;
    i_req_funct3 = '0; i_req_addr = '0; i_req_wdata = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("reset_rsp_err",   {31'd0, o_rsp_err},   32'd0);
    chk("reset_rsp_rdata", o_rsp_rdata,          32'd0);
    chk("reset_mem_wren",  {31'd0, o_mem_wren},  32'd0);
    chk("reset_mem_addr",  {16'd0, o_mem_addr},  32'd0);
    chk("reset_mem_wdata", o_mem_wdata,          32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 3'b000, 32'h12, 32'h00000055);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    issue(1'b0, 3'b001, 32'h10, 32'h0);
    issue(1'b0, 3'b010, 32'h11, 32'h0);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b1, 3'b011, 32'h10, 32'h12345678);
    drain();
    chk("sram_word4", mem[4], 32'hDE55BEEF);

    // SB aborted by reset while in WRITE: no expectations are queued for it.
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b000;
    i_req_addr = 32'h12; i_req_wdata = 32'hAA;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("abort_wren",      {31'd0, o_mem_wren},  32'd0);
    chk("abort_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    @(negedge i_clk);
    chk("abort_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("abort_mem_addr",  {16'd0, o_mem_addr},  32'd0);
    chk("abort_rsp_valid2", {31'd0, o_rsp_valid}, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    issue(1'b0, 3'b010, 32'h10, 32'h0);

    repeat (300) begin
      f3 = codes[$urandom_range(0, 9)];
      we = 1'($urandom_range(0, 1));
      if (we && f3[2] && !f3[1]) f3[2] = 1'b0;
      addr = ($urandom & 32'hFFFC0000) | 32'($urandom_range(0, 31));
      issue(we, f3, addr, $urandom);
    end
    drain();
    for (int i = 0; i < 8; i++) chk("final_sram", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
